rv_pipe_ctrl: RTL and testbench

//  Pipeline sequencing controller for the in-order core.

---
 rtl/rv_pipe_ctrl.sv | 154 +++++++++++++++
 tb/tb_rv_pipe_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rv_pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stalls, redirect flushes and mul/div occupancy.
// Optional perf counters are enabled by defining RV_PIPE_CTRL_PERF_EN.
module rv_pipe_ctrl #(
  parameter int unsigned NSTG        = 5,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned FLUSH_CYC   = 2,
  parameter int unsigned MC_STG      = 2,
  parameter int unsigned MC_TMO      = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSTG-1:0]  stall_req,
  input  logic             flush_req,
  input  logic             mc_start,
  input  logic             mc_done,
  output logic [NSTG-1:0]  stage_stall,
  output logic [NSTG-1:0]  stage_flush,
  output logic             mc_busy,
  output logic             mc_abort,
  output logic             mc_tmo,
  output logic [CNT_W-1:0] stall_cyc_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned TMO_W   = (MC_TMO > 2) ? $clog2(MC_TMO) : 1;
  localparam int unsigned FC_LAST = (FLUSH_CYC >= 2) ? FLUSH_CYC - 2 : 0;
  localparam int unsigned FC_W    = (FC_LAST > 0) ? $clog2(FC_LAST + 1) : 1;

  typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

  state_t           r_state;
  logic [TMO_W-1:0] r_tcnt;
  logic [FC_W-1:0]  r_fcnt;

  logic            w_in_run;
  logic            w_in_wait;
  logic            w_in_flush;
  logic            w_tmo_hit;
  logic            w_mc_req;
  logic            w_acc;
  logic [NSTG-1:0] w_eff;
  logic [NSTG-1:0] w_therm;
  logic [NSTG-1:0] w_flush_vec;
  logic [NSTG-1:0] w_stall_vec;

  assign w_in_run   = (r_state == RUN);
  assign w_in_wait  = (r_state == MC_WAIT);
  assign w_in_flush = (r_state == FLUSH);
  assign w_tmo_hit  = w_in_wait && (r_tcnt == TMO_W'(MC_TMO - 1));

  // Stall merge: every stage at or below the oldest requester holds, the stage above takes a bubble.
  always_comb begin
    w_mc_req    = (w_in_run && mc_start && !flush_req) ||
                  (w_in_wait && !mc_done && !w_tmo_hit);
    w_eff       = stall_req;
    w_eff[MC_STG] = stall_req[MC_STG] | w_mc_req;
    w_acc       = 1'b0;
    w_therm     = '0;
    w_flush_vec = '0;
    for (int i = int'(NSTG) - 1; i >= 0; i--) begin
      w_acc      = w_acc | w_eff[i];
      w_therm[i] = w_acc;
    end
    for (int i = 0; i < int'(NSTG) - 1; i++) begin
      w_flush_vec[i+1] = w_therm[i] & ~w_therm[i+1];
    end
    for (int i = 0; i < int'(NSTG); i++) begin
      if (flush_req && (i < int'(FLUSH_DEPTH))) begin
        w_flush_vec[i] = 1'b1;
      end
    end
    if (w_in_flush) begin
      w_flush_vec[0] = 1'b1;
    end
    w_stall_vec = w_therm & ~w_flush_vec;
  end

  assign stage_stall = rst ? '0 : w_stall_vec;
  assign stage_flush = rst ? '0 : w_flush_vec;
  assign mc_busy     = !rst && w_in_wait;
  assign mc_abort    = !rst && w_in_wait && flush_req;
  assign mc_tmo      = !rst && w_tmo_hit && !mc_done && !flush_req;

  // Sequencing FSM with multicycle timeout and flush-length counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_tcnt  <= '0;
      r_fcnt  <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (flush_req) begin
            if (FLUSH_CYC > 1) begin
              r_state <= FLUSH;
              r_fcnt  <= '0;
            end
          end else if (mc_start) begin
            r_state <= MC_WAIT;
            r_tcnt  <= '0;
          end
        end
        MC_WAIT: begin
          if (flush_req) begin
            r_state <= (FLUSH_CYC > 1) ? FLUSH : RUN;
            r_fcnt  <= '0;
          end else if (mc_done || w_tmo_hit) begin
            r_state <= RUN;
          end else begin
            r_tcnt <= r_tcnt + TMO_W'(1);
          end
        end
        FLUSH: begin
          if (flush_req) begin
            r_fcnt <= '0;
          end else if (r_fcnt == FC_W'(FC_LAST)) begin
            r_state <= RUN;
          end else begin
            r_fcnt <= r_fcnt + FC_W'(1);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef RV_PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((|w_stall_vec) && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush_req && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cyc_cnt = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;
`else
  assign stall_cyc_cnt = '0;
  assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Scoreboard bench for rv_pipe_ctrl: driver queues per-cycle expectations, monitor compares on negedge.
module tb_rv_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  stall_req;
  logic        flush_req;
  logic        mc_start;
  logic        mc_done;
  logic [4:0]  stage_stall;
  logic [4:0]  stage_flush;
  logic        mc_busy;
  logic        mc_abort;
  logic        mc_tmo;
  logic [31:0] stall_cyc_cnt;
  logic [31:0] flush_cnt;

  typedef struct {
    string       nm;
    logic [4:0]  s;
    logic [4:0]  f;
    logic        b;
    logic        a;
    logic        t;
    bit          pc;
    logic [31:0] ps;
    logic [31:0] pf;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit          g_pc = 1'b0;
  logic [31:0] g_ps = '0;
  logic [31:0] g_pf = '0;

  rv_pipe_ctrl #(
    .NSTG(5), .FLUSH_DEPTH(2), .FLUSH_CYC(2), .MC_STG(2), .MC_TMO(8), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .mc_start(mc_start), .mc_done(mc_done), .stage_stall(stage_stall),
    .stage_flush(stage_flush), .mc_busy(mc_busy), .mc_abort(mc_abort),
    .mc_tmo(mc_tmo), .stall_cyc_cnt(stall_cyc_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input string nm, input logic r, input logic [4:0] sr,
                       input logic fr, input logic ms, input logic md,
                       input logic [4:0] es, input logic [4:0] ef,
                       input logic eb, input logic ea, input logic et);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall_req = sr; flush_req = fr; mc_start = ms; mc_done = md;
    e.nm = nm; e.s = es; e.f = ef; e.b = eb; e.a = ea; e.t = et;
    e.pc = g_pc; e.ps = g_ps; e.pf = g_pf;
    q.push_back(e);
    g_pc = 1'b0;
  endtask

  task automatic idle(input string nm);
    drive(nm, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, 5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if ({stage_stall, stage_flush, mc_busy, mc_abort, mc_tmo} !== {e.s, e.f, e.b, e.a, e.t}) begin
          n_err++;
          $display("FAIL %s: got stall=%b flush=%b busy=%b abort=%b tmo=%b, required stall=%b flush=%b busy=%b abort=%b tmo=%b",
                   e.nm, stage_stall, stage_flush, mc_busy, mc_abort, mc_tmo, e.s, e.f, e.b, e.a, e.t);
        end
        if (e.pc) begin
          n_cmp++;
          if ({stall_cyc_cnt, flush_cnt} !== {e.ps, e.pf}) begin
            n_err++;
            $display("FAIL %s_perf: got stall_cyc_cnt=%0d flush_cnt=%0d, required %0d %0d",
                     e.nm, stall_cyc_cnt, flush_cnt, e.ps, e.pf);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_req = '0; flush_req = 1'b0; mc_start = 1'b0; mc_done = 1'b0;

    // T1 reset with random inputs
    for (int k = 0; k < 2; k++) begin
      drive("rst_rand", 1'b1, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
    end
    g_pc = 1'b1; g_ps = 0; g_pf = 0;
    idle("run_after_rst");

    // T2 stall merge
    drive("stall_mid", 0, 5'b00100, 0, 0, 0, 5'b00111, 5'b01000, 0, 0, 0);
    idle("stall_rel");
    drive("stall_top", 0, 5'b10000, 0, 0, 0, 5'b11111, 5'b00000, 0, 0, 0);
    drive("stall_bot", 0, 5'b00001, 0, 0, 0, 5'b00001, 5'b00010, 0, 0, 0);

    // T3 multicycle with done
    drive("mc_t0", 0, 5'b0, 0, 1, 0, 5'b00111, 5'b01000, 0, 0, 0);
    for (int k = 1; k <= 3; k++) drive("mc_wait", 0, 5'b0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 0);
    drive("mc_done", 0, 5'b0, 0, 0, 1, 5'b0, 5'b0, 1, 0, 0);
    idle("mc_t5_run");

    // T4 timeout
    drive("tmo_t0", 0, 5'b0, 0, 1, 0, 5'b00111, 5'b01000, 0, 0, 0);
    for (int k = 1; k <= 7; k++) drive("tmo_wait", 0, 5'b0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 0);
    drive("tmo_t8", 0, 5'b0, 0, 0, 0, 5'b0, 5'b0, 1, 0, 1);
    idle("tmo_t9_run");

    // mc_done on the timeout cycle suppresses mc_tmo
    drive("tdone_t0", 0, 5'b0, 0, 1, 0, 5'b00111, 5'b01000, 0, 0, 0);
    for (int k = 1; k <= 7; k++) drive("tdone_wait", 0, 5'b0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 0);
    drive("tdone_t8", 0, 5'b0, 0, 0, 1, 5'b0, 5'b0, 1, 0, 0);
    idle("tdone_t9_run");

    // T5 flush priority inside MC_WAIT
    drive("abort_t0", 0, 5'b0, 0, 1, 0, 5'b00111, 5'b01000, 0, 0, 0);
    drive("abort_wait", 0, 5'b0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 0);
    drive("abort_flush", 0, 5'b11111, 1, 0, 0, 5'b11100, 5'b00011, 1, 1, 0);
    drive("abort_fstate", 0, 5'b0, 0, 0, 0, 5'b0, 5'b00001, 0, 0, 0);
    idle("abort_run");

    // Flush wins over a stall in RUN
    drive("fl_stall", 0, 5'b00010, 1, 0, 0, 5'b00000, 5'b00111, 0, 0, 0);
    drive("fl_stall_fs", 0, 5'b0, 0, 0, 0, 5'b0, 5'b00001, 0, 0, 0);
    idle("fl_stall_run");

    // Flush inside FLUSH restarts the sequence
    drive("fl_rs_t0", 0, 5'b0, 1, 0, 0, 5'b0, 5'b00011, 0, 0, 0);
    drive("fl_rs_t1", 0, 5'b0, 1, 0, 0, 5'b0, 5'b00011, 0, 0, 0);
    drive("fl_rs_t2", 0, 5'b0, 0, 0, 0, 5'b0, 5'b00001, 0, 0, 0);
    idle("fl_rs_run");

    // mc_start in FLUSH and mc_done in RUN are ignored
    drive("ign_fl", 0, 5'b0, 1, 0, 0, 5'b0, 5'b00011, 0, 0, 0);
    drive("ign_ms", 0, 5'b0, 0, 1, 0, 5'b0, 5'b00001, 0, 0, 0);
    idle("ign_ms_run");
    drive("ign_md", 0, 5'b0, 0, 0, 1, 5'b0, 5'b0, 0, 0, 0);
    idle("ign_md_run");

    // Reset mid-operation drops the op without mc_abort
    drive("mrst_t0", 0, 5'b0, 0, 1, 0, 5'b00111, 5'b01000, 0, 0, 0);
    drive("mrst_wait", 0, 5'b0, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 0);
    drive("mrst_rst", 1, 5'b00100, 1, 0, 0, 5'b0, 5'b0, 0, 0, 0);
    idle("mrst_run");

    // T6 perf counters
    drive("perf_rst", 1, 5'b0, 0, 0, 0, 5'b0, 5'b0, 0, 0, 0);
    g_pc = 1'b1; g_ps = 0; g_pf = 0;
    idle("perf_zero");
    for (int k = 0; k < 3; k++) drive("perf_stall", 0, 5'b00001, 0, 0, 0, 5'b00001, 5'b00010, 0, 0, 0);
    drive("perf_fl1", 0, 5'b0, 1, 0, 0, 5'b0, 5'b00011, 0, 0, 0);
    drive("perf_fs1", 0, 5'b0, 0, 0, 0, 5'b0, 5'b00001, 0, 0, 0);
    drive("perf_fl2", 0, 5'b0, 1, 0, 0, 5'b0, 5'b00011, 0, 0, 0);
    drive("perf_fs2", 0, 5'b0, 0, 0, 0, 5'b0, 5'b00001, 0, 0, 0);
    g_pc = 1'b1;
`ifdef RV_PIPE_CTRL_PERF_EN
    g_ps = 3; g_pf = 2;
`else
    g_ps = 0; g_pf = 0;
`endif
    idle("perf_final");

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, required 0", q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
